// File: rtl/arbitro_mem_dados.sv
// rtl/arbitro_mem_dados.sv - two-port data memory arbiter with run/halt control
// Port A (processor) and port B (loader/debug) share one single-port 64-word memory.
module arbitro_mem_dados #(
    parameter int PROFUNDIDADE = 64,
    parameter int MAX_ESPERA   = 4,
    parameter int LIMITE_PC    = 616
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_end,
    input  logic [31:0] a_dados,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [31:0] a_rdata,
    output logic        a_erro,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_end,
    input  logic [31:0] b_dados,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [31:0] b_rdata,
    output logic        b_erro,
    input  logic [31:0] pc_atual,
    input  logic        retomar,
    output logic        parado,
    output logic [31:0] pc_final,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_posicao,
    output logic [31:0] mem_dados,
    input  logic [31:0] mem_saida
);

    typedef enum logic {EXECUCAO, PARADO} estado_t;

    localparam int EW = $clog2(MAX_ESPERA + 1);

    estado_t       estado;
    logic [EW-1:0] espera_b;

    logic        a_ok;
    logic        b_ok;
    logic        gnt_any;
    logic        sel_we;
    logic        sel_ok;
    logic [31:0] sel_end;
    logic [31:0] sel_dados;

    assign a_ok   = (a_end < 32'(PROFUNDIDADE));
    assign b_ok   = (b_end < 32'(PROFUNDIDADE));
    assign parado = (estado == PARADO);

    // A has priority unless B has already been starved for MAX_ESPERA cycles.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (estado == PARADO) begin
                b_gnt = b_req;
            end else if (a_req && b_req) begin
                if (espera_b == EW'(MAX_ESPERA)) begin
                    b_gnt = 1'b1;
                end else begin
                    a_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end
    end

    always_comb begin
        gnt_any     = a_gnt || b_gnt;
        sel_we      = b_gnt ? b_we    : a_we;
        sel_ok      = b_gnt ? b_ok    : a_ok;
        sel_end     = b_gnt ? b_end   : a_end;
        sel_dados   = b_gnt ? b_dados : a_dados;
        mem_write   = gnt_any && sel_ok && sel_we;
        mem_read    = gnt_any && sel_ok && !sel_we;
        mem_posicao = gnt_any ? sel_end   : 32'd0;
        mem_dados   = gnt_any ? sel_dados : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado   <= EXECUCAO;
            espera_b <= '0;
            pc_final <= 32'd0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_erro   <= 1'b0;
            b_erro   <= 1'b0;
            a_rdata  <= 32'd0;
            b_rdata  <= 32'd0;
        end else begin
            a_rvalid <= a_gnt && a_ok && !a_we;
            b_rvalid <= b_gnt && b_ok && !b_we;
            a_erro   <= a_gnt && !a_ok;
            b_erro   <= b_gnt && !b_ok;
            if (a_gnt && a_ok && !a_we) begin
                a_rdata <= mem_saida;
            end
            if (b_gnt && b_ok && !b_we) begin
                b_rdata <= mem_saida;
            end

            if (estado == PARADO || !b_req || b_gnt) begin
                espera_b <= '0;
            end else if (espera_b != EW'(MAX_ESPERA)) begin
                espera_b <= espera_b + EW'(1);
            end

            case (estado)
                EXECUCAO: begin
                    if (pc_atual > 32'(LIMITE_PC)) begin
                        estado   <= PARADO;
                        pc_final <= pc_atual;
                    end
                end
                PARADO: begin
                    if (retomar) begin
                        estado <= EXECUCAO;
                    end
                end
                default: estado <= EXECUCAO;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mem_dados.sv
// tb/tb_arbitro_mem_dados.sv - directed bench with cycle-level reference model
module tb_arbitro_mem_dados;

    localparam int PROF = 64;
    localparam int MAXE = 4;
    localparam int LIM  = 616;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_we, b_req, b_we, retomar;
    logic [31:0] a_end, a_dados, b_end, b_dados, pc_atual;
    logic        a_gnt, a_rvalid, a_erro, b_gnt, b_rvalid, b_erro, parado;
    logic [31:0] a_rdata, b_rdata, pc_final;
    logic        mem_write, mem_read;
    logic [31:0] mem_posicao, mem_dados, mem_saida;

    logic [31:0] env_mem [PROF];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    arbitro_mem_dados #(
        .PROFUNDIDADE(PROF),
        .MAX_ESPERA  (MAXE),
        .LIMITE_PC   (LIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_req      (a_req),
        .a_we       (a_we),
        .a_end      (a_end),
        .a_dados    (a_dados),
        .a_gnt      (a_gnt),
        .a_rvalid   (a_rvalid),
        .a_rdata    (a_rdata),
        .a_erro     (a_erro),
        .b_req      (b_req),
        .b_we       (b_we),
        .b_end      (b_end),
        .b_dados    (b_dados),
        .b_gnt      (b_gnt),
        .b_rvalid   (b_rvalid),
        .b_rdata    (b_rdata),
        .b_erro     (b_erro),
        .pc_atual   (pc_atual),
        .retomar    (retomar),
        .parado     (parado),
        .pc_final   (pc_final),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_posicao(mem_posicao),
        .mem_dados  (mem_dados),
        .mem_saida  (mem_saida)
    );

    // Memory the DUT talks to; preloaded with a recognisable pattern on reset.
    assign mem_saida = env_mem[mem_posicao[5:0]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PROF; i++) env_mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_write) begin
            env_mem[mem_posicao[5:0]] <= mem_dados;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, want);
        end
    endtask

    // Reference model: state after the most recent edge, advanced once per cycle.
    bit          m_ok = 1'b0;
    bit          m_halt;
    int          m_wait;
    logic [31:0] m_pcf, m_ard, m_brd;
    bit          m_arv, m_brv, m_aer, m_ber;
    logic [31:0] m_mem [PROF];

    always @(negedge clk) begin : model
        bit          ga, gb, wwe, inr;
        logic [31:0] waddr, wdata;
        ga = 1'b0;
        gb = 1'b0;
        if (!rst) begin
            if (m_halt) gb = b_req;
            else if (a_req && b_req) begin
                if (m_wait == MAXE) gb = 1'b1;
                else ga = 1'b1;
            end else begin
                ga = a_req;
                gb = b_req;
            end
        end
        waddr = gb ? b_end   : a_end;
        wdata = gb ? b_dados : a_dados;
        wwe   = gb ? b_we    : a_we;
        inr   = (waddr < PROF);

        if (m_ok) begin
            chk("m_a_gnt", 32'(a_gnt), 32'(ga));
            chk("m_b_gnt", 32'(b_gnt), 32'(gb));
            chk("m_mem_write", 32'(mem_write), 32'((ga || gb) && inr && wwe));
            chk("m_mem_read", 32'(mem_read), 32'((ga || gb) && inr && !wwe));
            if (!(ga || gb)) begin
                chk("m_posicao_idle", mem_posicao, 32'd0);
                chk("m_dados_idle", mem_dados, 32'd0);
            end else if (inr) begin
                chk("m_posicao", mem_posicao, waddr);
                chk("m_dados", mem_dados, wdata);
            end
            chk("m_a_rvalid", 32'(a_rvalid), 32'(m_arv));
            chk("m_b_rvalid", 32'(b_rvalid), 32'(m_brv));
            chk("m_a_erro", 32'(a_erro), 32'(m_aer));
            chk("m_b_erro", 32'(b_erro), 32'(m_ber));
            chk("m_a_rdata", a_rdata, m_ard);
            chk("m_b_rdata", b_rdata, m_brd);
            chk("m_parado", 32'(parado), 32'(m_halt));
            chk("m_pc_final", pc_final, m_pcf);
        end

        if (rst) begin
            m_ok   = 1'b1;
            m_halt = 1'b0;
            m_wait = 0;
            m_pcf  = 32'd0;
            m_ard  = 32'd0;
            m_brd  = 32'd0;
            m_arv  = 1'b0;
            m_brv  = 1'b0;
            m_aer  = 1'b0;
            m_ber  = 1'b0;
            for (int i = 0; i < PROF; i++) m_mem[i] = 32'h1000_0000 + 32'(i);
        end else begin
            m_arv = ga && inr && !wwe;
            m_brv = gb && inr && !wwe;
            m_aer = ga && !inr;
            m_ber = gb && !inr;
            if (m_arv) m_ard = m_mem[waddr[5:0]];
            if (m_brv) m_brd = m_mem[waddr[5:0]];
            if ((ga || gb) && inr && wwe) m_mem[waddr[5:0]] = wdata;
            if (m_halt || !b_req || gb) m_wait = 0;
            else if (m_wait < MAXE) m_wait = m_wait + 1;
            if (!m_halt && pc_atual > LIM) begin
                m_halt = 1'b1;
                m_pcf  = pc_atual;
            end else if (m_halt && retomar) begin
                m_halt = 1'b0;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    task automatic drv_a(input bit req, input bit we, input logic [31:0] e, input logic [31:0] d);
        a_req = req; a_we = we; a_end = e; a_dados = d;
    endtask

    task automatic drv_b(input bit req, input bit we, input logic [31:0] e, input logic [31:0] d);
        b_req = req; b_we = we; b_end = e; b_dados = d;
    endtask

    initial begin
        rst = 1'b1; retomar = 1'b0; pc_atual = 32'd0;
        drv_a(1, 0, 32'd3, 32'd0);
        drv_b(0, 0, 32'd0, 32'd0);
        nxt();
        look();
        chk("rst_a_gnt", 32'(a_gnt), 32'd0);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_parado", 32'(parado), 32'd0);
        chk("rst_pc_final", pc_final, 32'd0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_a_rdata", a_rdata, 32'd0);
        nxt();

        // B writes, A reads the same word next cycle
        rst = 1'b0;
        drv_a(0, 0, 32'd0, 32'd0);
        drv_b(1, 1, 32'd5, 32'hDEAD_BEEF);
        look();
        chk("bw_b_gnt", 32'(b_gnt), 32'd1);
        chk("bw_mem_write", 32'(mem_write), 32'd1);
        chk("bw_posicao", mem_posicao, 32'd5);
        chk("bw_dados", mem_dados, 32'hDEAD_BEEF);
        nxt();
        drv_b(0, 0, 32'd0, 32'd0);
        drv_a(1, 0, 32'd5, 32'd0);
        look();
        chk("ar_a_gnt", 32'(a_gnt), 32'd1);
        chk("ar_mem_read", 32'(mem_read), 32'd1);
        chk("ar_posicao", mem_posicao, 32'd5);
        nxt();
        drv_a(0, 0, 32'd0, 32'd0);
        look();
        chk("ar_a_rvalid", 32'(a_rvalid), 32'd1);
        chk("ar_a_rdata", a_rdata, 32'hDEAD_BEEF);
        nxt();

        // Contention: B gets through every fifth cycle
        for (int i = 1; i <= 10; i++) begin
            drv_a(1, 0, 32'd1, 32'd0);
            drv_b(1, 0, 32'd2, 32'd0);
            look();
            chk("ct_a_gnt", 32'(a_gnt), 32'(i != 5 && i != 10));
            chk("ct_b_gnt", 32'(b_gnt), 32'(i == 5 || i == 10));
            nxt();
        end

        // Out-of-range write by A, out-of-range read by B
        drv_b(0, 0, 32'd0, 32'd0);
        drv_a(1, 1, 32'd64, 32'h1234_5678);
        look();
        chk("oor_a_gnt", 32'(a_gnt), 32'd1);
        chk("oor_mem_write", 32'(mem_write), 32'd0);
        nxt();
        drv_a(0, 0, 32'd0, 32'd0);
        drv_b(1, 0, 32'd100, 32'd0);
        look();
        chk("oor_a_erro", 32'(a_erro), 32'd1);
        chk("oor_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("oor_b_gnt", 32'(b_gnt), 32'd1);
        chk("oor_b_mem_read", 32'(mem_read), 32'd0);
        nxt();
        drv_b(0, 0, 32'd0, 32'd0);
        look();
        chk("oor_b_erro", 32'(b_erro), 32'd1);
        chk("oor_a_erro_pulse", 32'(a_erro), 32'd0);
        chk("oor_b_rvalid", 32'(b_rvalid), 32'd0);
        chk("oor_b_rdata_hold", b_rdata, 32'h1000_0002);
        chk("oor_mem0", env_mem[0], 32'h1000_0000);
        nxt();

        // Halt: A served in the halting cycle, then B owns the memory
        pc_atual = 32'd620;
        drv_a(1, 0, 32'd2, 32'd0);
        look();
        chk("h_a_gnt", 32'(a_gnt), 32'd1);
        chk("h_parado0", 32'(parado), 32'd0);
        nxt();
        for (int i = 0; i < 5; i++) begin
            drv_a(1, 0, 32'd7, 32'd0);
            drv_b(1, 0, 32'(i), 32'd0);
            look();
            chk("h_parado", 32'(parado), 32'd1);
            chk("h_pc_final", pc_final, 32'd620);
            chk("h_a_gnt", 32'(a_gnt), 32'd0);
            chk("h_b_gnt", 32'(b_gnt), 32'd1);
            chk("h_posicao", mem_posicao, 32'(i));
            if (i == 0) begin
                chk("h_a_rvalid", 32'(a_rvalid), 32'd1);
                chk("h_a_rdata", a_rdata, 32'h1000_0002);
            end else begin
                chk("h_b_rvalid", 32'(b_rvalid), 32'd1);
                chk("h_b_rdata", b_rdata, 32'h1000_0000 + 32'(i - 1));
            end
            nxt();
        end
        drv_b(0, 0, 32'd0, 32'd0);
        retomar  = 1'b1;
        pc_atual = 32'd0;
        look();
        chk("h_b_rvalid_last", 32'(b_rvalid), 32'd1);
        chk("h_b_rdata_last", b_rdata, 32'h1000_0004);
        chk("h_a_gnt_still", 32'(a_gnt), 32'd0);
        nxt();

        // Resumed: A granted again
        retomar = 1'b0;
        drv_a(1, 0, 32'd3, 32'd0);
        look();
        chk("r_parado", 32'(parado), 32'd0);
        chk("r_a_gnt", 32'(a_gnt), 32'd1);
        nxt();

        // Reset right after a granted read
        pc_atual = 32'd700;
        nxt();
        rst = 1'b1;
        drv_a(0, 0, 32'd0, 32'd0);
        pc_atual = 32'd0;
        nxt();
        rst = 1'b0;
        look();
        chk("rr_a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rr_a_rdata", a_rdata, 32'd0);
        chk("rr_parado", 32'(parado), 32'd0);
        chk("rr_pc_final", pc_final, 32'd0);
        nxt();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
